ni_packetizer: RTL and testbench

//  PE-side network-interface injector. Accepts a message request (destination
//  X/Y plus payload length) and a stream of 32-bit payload words from the

---
 rtl/ni_packetizer.sv | 149 ++++++++++++++
 tb/tb_ni_packetizer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ni_packetizer.sv
// PE-side network-interface injector: turns a message request plus a payload
// word stream into head/body/tail flits on the router PE channel, credit-gated.
module ni_packetizer #(
  parameter int FLIT_W    = 32,
  parameter int ADDR_W    = 4,
  parameter int LEN_W     = 4,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pe_req_valid,
  output logic              pe_req_ready,
  input  logic [ADDR_W-1:0] pe_dst_x,
  input  logic [ADDR_W-1:0] pe_dst_y,
  input  logic [LEN_W-1:0]  pe_len,
  input  logic              pe_data_valid,
  input  logic [FLIT_W-1:0] pe_data,
  output logic              pe_data_ready,
  input  logic              credit_in,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  output logic [1:0]        flit_type,
  output logic              busy,
  output logic              credit_err
);

  localparam int CRED_W = $clog2(BUF_DEPTH + 1);
  localparam int PAD_W  = FLIT_W - 2 * ADDR_W - LEN_W;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    BODY
  } state_t;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } ftype_t;

  state_t              state;
  logic [CRED_W-1:0]   credits;
  logic [LEN_W-1:0]    remaining;
  logic [ADDR_W-1:0]   dst_x_q;
  logic [ADDR_W-1:0]   dst_y_q;
  logic [LEN_W-1:0]    len_q;

  logic                has_credit;
  logic                req_fire;
  logic                head_launch;
  logic                body_launch;
  logic                launch;
  logic                last_word;
  logic [FLIT_W-1:0]   header;

  // Handshake outputs depend only on registered state, never on the
  // same-cycle valids, so there is no combinational path back to the PE.
  assign has_credit    = (credits != '0);
  assign pe_req_ready  = (state == IDLE);
  assign pe_data_ready = (state == BODY) && has_credit;
  assign busy          = (state != IDLE);

  assign req_fire    = pe_req_valid && pe_req_ready;
  assign head_launch = (state == HEAD) && has_credit;
  assign body_launch = pe_data_valid && pe_data_ready;
  assign launch      = head_launch || body_launch;
  assign last_word   = (remaining == LEN_W'(1));
  assign header      = {dst_x_q, dst_y_q, len_q, {PAD_W{1'b0}}};

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      dst_x_q   <= '0;
      dst_y_q   <= '0;
      len_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_fire) begin
            dst_x_q <= pe_dst_x;
            dst_y_q <= pe_dst_y;
            len_q   <= pe_len;
            state   <= HEAD;
          end
        end
        HEAD: begin
          if (has_credit) begin
            if (len_q == '0) begin
              state <= IDLE;
            end else begin
              remaining <= len_q;
              state     <= BODY;
            end
          end
        end
        BODY: begin
          if (body_launch) begin
            remaining <= remaining - LEN_W'(1);
            if (last_word) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flit register: loaded only on launch, so data and type hold when invalid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_valid <= 1'b0;
      flit_out   <= '0;
      flit_type  <= '0;
    end else begin
      flit_valid <= launch;
      if (head_launch) begin
        flit_out  <= header;
        flit_type <= (len_q == '0) ? FT_SINGLE : FT_HEAD;
      end else if (body_launch) begin
        flit_out  <= pe_data;
        flit_type <= last_word ? FT_TAIL : FT_BODY;
      end
    end
  end

  // Credit counter mirrors free router buffer slots; a return while already
  // full means the router and this counter disagree, which is latched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits    <= CRED_MAX;
      credit_err <= 1'b0;
    end else begin
      unique case ({launch, credit_in})
        2'b10: credits <= credits - CRED_W'(1);
        2'b01: begin
          if (credits == CRED_MAX) credit_err <= 1'b1;
          else                     credits    <= credits + CRED_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ni_packetizer.sv
// Self-checking bench for ni_packetizer: table of packets plus hand-written
// credit-stall, reset and credit-error sequences, checked via a flit scoreboard.
module tb_ni_packetizer;

  localparam int FLIT_W = 32;
  localparam int ADDR_W = 4;
  localparam int LEN_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              pe_req_valid = 1'b0;
  logic              pe_req_ready;
  logic [ADDR_W-1:0] pe_dst_x = '0;
  logic [ADDR_W-1:0] pe_dst_y = '0;
  logic [LEN_W-1:0]  pe_len = '0;
  logic              pe_data_valid = 1'b0;
  logic [FLIT_W-1:0] pe_data = '0;
  logic              pe_data_ready;
  logic              credit_in;
  logic [FLIT_W-1:0] flit_out;
  logic              flit_valid;
  logic [1:0]        flit_type;
  logic              busy;
  logic              credit_err;

  logic auto_credit   = 1'b0;
  logic manual_credit = 1'b0;

  // Router model: returns a slot the cycle after each flit, or on demand.
  assign credit_in = (auto_credit & flit_valid) | manual_credit;

  ni_packetizer #(
    .FLIT_W(FLIT_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .BUF_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .pe_req_valid(pe_req_valid), .pe_req_ready(pe_req_ready),
    .pe_dst_x(pe_dst_x), .pe_dst_y(pe_dst_y), .pe_len(pe_len),
    .pe_data_valid(pe_data_valid), .pe_data(pe_data), .pe_data_ready(pe_data_ready),
    .credit_in(credit_in),
    .flit_out(flit_out), .flit_valid(flit_valid), .flit_type(flit_type),
    .busy(busy), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [FLIT_W-1:0] data;
    logic [1:0]        ftype;
  } flit_t;

  typedef struct {
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
    logic [LEN_W-1:0]  len;
    logic [FLIT_W-1:0] head;
    logic [1:0]        htype;
  } vec_t;

  flit_t sb[$];
  int    flit_cyc[$];
  int    errors = 0;
  int    checks = 0;
  int    cycle  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cycle++;

  // Scoreboard monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst && flit_valid) begin
      flit_cyc.push_back(cycle);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_flit: got %h type %b expected no flit", flit_out, flit_type);
      end else begin
        flit_t e;
        e = sb.pop_front();
        check("flit_data", flit_out, e.data);
        check("flit_type", flit_type, e.ftype);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic request(input logic [ADDR_W-1:0] x, input logic [ADDR_W-1:0] y,
                         input logic [LEN_W-1:0] l, input logic [FLIT_W-1:0] head,
                         input logic [1:0] htype, output int acc);
    int    w;
    flit_t f;
    w = 0;
    pe_dst_x = x; pe_dst_y = y; pe_len = l; pe_req_valid = 1'b1;
    while (!pe_req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("req_accept", pe_req_ready, 1);
    acc = cycle;
    if (pe_req_ready) begin
      f.data = head; f.ftype = htype;
      sb.push_back(f);
    end
    @(negedge clk);
    pe_req_valid = 1'b0;
  endtask

  // Offers words first..len-1; gives up (dropping valid) after max_wait stalled cycles.
  task automatic send_words(input int first, input int len, input int max_wait,
                            output int sent, output int waited);
    sent = 0;
    waited = 0;
    for (int i = first; i < len; i++) begin
      logic [FLIT_W-1:0] d;
      int                w;
      flit_t             f;
      d = $urandom;
      w = 0;
      pe_data_valid = 1'b1;
      pe_data = d;
      while (!pe_data_ready && w < max_wait) begin
        @(negedge clk);
        w++;
      end
      waited += w;
      if (!pe_data_ready) begin
        pe_data_valid = 1'b0;
        return;
      end
      f.data = d;
      f.ftype = (i == len - 1) ? 2'b10 : 2'b00;
      sb.push_back(f);
      sent++;
      @(negedge clk);
    end
    pe_data_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("drain_empty", sb.size(), 0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    vec_t vecs[5];
    int   acc, sent, waited;

    vecs[0] = '{x: 4'd2,  y: 4'd3,  len: 4'd3,  head: 32'h2330_0000, htype: 2'b01};
    vecs[1] = '{x: 4'd1,  y: 4'd0,  len: 4'd0,  head: 32'h1000_0000, htype: 2'b11};
    vecs[2] = '{x: 4'd15, y: 4'd15, len: 4'd15, head: 32'hFFF0_0000, htype: 2'b01};
    vecs[3] = '{x: 4'd0,  y: 4'd5,  len: 4'd1,  head: 32'h0510_0000, htype: 2'b01};
    vecs[4] = '{x: 4'd10, y: 4'd4,  len: 4'd2,  head: 32'hA420_0000, htype: 2'b01};

    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", pe_req_ready, 1);
    check("rst_data_ready", pe_data_ready, 0);
    check("rst_flit_valid", flit_valid, 0);
    check("rst_flit_out", flit_out, 0);
    check("rst_flit_type", flit_type, 0);
    check("rst_busy", busy, 0);
    check("rst_credit_err", credit_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // Table of packets with the router returning credits promptly.
    auto_credit = 1'b1;
    for (int v = 0; v < 5; v++) begin
      flit_cyc.delete();
      request(vecs[v].x, vecs[v].y, vecs[v].len, vecs[v].head, vecs[v].htype, acc);
      send_words(0, int'(vecs[v].len), 10, sent, waited);
      drain();
      check("pkt_flit_count", flit_cyc.size(), int'(vecs[v].len) + 1);
      for (int i = 0; i < flit_cyc.size(); i++)
        check("pkt_flit_cycle", flit_cyc[i], acc + 2 + i);
      check("pkt_idle_after", busy, 0);
      check("pkt_req_ready_after", pe_req_ready, 1);
    end
    auto_credit = 1'b0;

    // Credit stall: four credits carry header plus three body words.
    flit_cyc.delete();
    request(4'd3, 4'd1, 4'd6, 32'h3160_0000, 2'b01, acc);
    send_words(0, 6, 4, sent, waited);
    check("stall_sent", sent, 3);
    repeat (2) @(negedge clk);
    check("stall_flits", flit_cyc.size(), 4);
    check("stall_data_ready", pe_data_ready, 0);
    check("stall_busy", busy, 1);

    // A single returned credit releases exactly one more word.
    manual_credit = 1'b1;
    @(negedge clk);
    manual_credit = 1'b0;
    send_words(3, 6, 2, sent, waited);
    check("pulse_sent", sent, 1);
    repeat (2) @(negedge clk);
    check("pulse_flits", flit_cyc.size(), 5);

    // Launch coinciding with a credit return at credits==1: no stall.
    manual_credit = 1'b1;
    @(negedge clk);
    send_words(4, 6, 4, sent, waited);
    manual_credit = 1'b0;
    check("simul_sent", sent, 2);
    check("simul_no_stall", waited, 0);
    repeat (2) @(negedge clk);
    check("simul_flits", flit_cyc.size(), 7);
    check("simul_back_to_back", flit_cyc[6] - flit_cyc[5], 1);
    check("simul_idle", busy, 0);

    // Exactly one credit should remain: header goes, body stalls.
    request(4'd4, 4'd4, 4'd2, 32'h4420_0000, 2'b01, acc);
    send_words(0, 2, 3, sent, waited);
    check("one_credit_sent", sent, 0);
    repeat (2) @(negedge clk);
    check("one_credit_flits", flit_cyc.size(), 8);
    check("one_credit_busy", busy, 1);

    // Reset while mid-BODY drops the packet and restores credits.
    rst = 1'b0;
    #1;
    check("midrst_flit_valid", flit_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_req_ready", pe_req_ready, 1);
    check("midrst_data_ready", pe_data_ready, 0);
    sb.delete();
    flit_cyc.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    request(4'd7, 4'd2, 4'd3, 32'h7230_0000, 2'b01, acc);
    send_words(0, 3, 10, sent, waited);
    check("postrst_sent", sent, 3);
    check("postrst_wait", waited, 1);
    drain();
    check("postrst_flits", flit_cyc.size(), 4);

    // Return all four credits: reaching the maximum is not an error.
    manual_credit = 1'b1;
    repeat (4) @(negedge clk);
    manual_credit = 1'b0;
    check("full_no_err", credit_err, 0);
    // One more return while full is spurious and latches the error.
    manual_credit = 1'b1;
    @(negedge clk);
    manual_credit = 1'b0;
    check("spurious_err", credit_err, 1);
    repeat (3) @(negedge clk);
    check("spurious_err_sticky", credit_err, 1);

    // Count saturated at four: header plus three words, then stall.
    flit_cyc.delete();
    request(4'd9, 4'd8, 4'd4, 32'h9840_0000, 2'b01, acc);
    send_words(0, 4, 3, sent, waited);
    check("sat_sent", sent, 3);
    repeat (2) @(negedge clk);
    check("sat_flits", flit_cyc.size(), 4);
    check("sat_err_still", credit_err, 1);

    rst = 1'b0;
    #1;
    check("err_cleared", credit_err, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Header-only packet after reset.
    flit_cyc.delete();
    request(4'd1, 4'd0, 4'd0, 32'h1000_0000, 2'b11, acc);
    drain();
    check("final_flits", flit_cyc.size(), 1);
    check("final_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
